// File: rtl/uart_rx_64_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_64_if
//  Purpose  : Serial line plus received-word bus for the 64-bit UART receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_64_if;
    logic        uart_rxd;
    logic [63:0] data_64;
    logic        data_valid;
    logic        frame_err;
    logic [2:0]  byte_cnt;

    // master drives the line and observes the word; slave is the receiver
    modport master (
        output uart_rxd,
        input  data_64,
        input  data_valid,
        input  frame_err,
        input  byte_cnt
    );

    modport slave (
        input  uart_rxd,
        output data_64,
        output data_valid,
        output frame_err,
        output byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_64.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_64
//  Purpose  : 8N1 UART receiver assembling eight bytes (MSB byte first) into a
//             64-bit word. Optional macro RX_TIMEOUT_EN drops a stale partial
//             word after TIMEOUT_BITS idle bit periods.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_64 #(
    parameter int CLK_F        = 50_000_000,
    parameter int UART_BPS     = 115200,
    parameter int CLK_GOAL     = CLK_F / UART_BPS,
    parameter int TIMEOUT_BITS = 20
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    uart_rx_64_if.slave rx
);

    localparam int c_CNT_W = $clog2(CLK_GOAL);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLK_GOAL / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLK_GOAL - 1);

    if (CLK_GOAL < 4 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("uart_rx_64: CLK_GOAL must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_rxd_s1;
    logic               r_rxd_s2;
    logic               r_rxd_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_byte;
    logic [55:0]        r_word;
    logic [63:0]        r_data_64;
    logic               r_data_valid;
    logic               r_frame_err;
    logic [2:0]         r_byte_cnt;
    logic               w_start_edge;

`ifdef RX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_BITS * CLK_GOAL);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_BITS * CLK_GOAL - 1);
    logic [c_TO_W-1:0]  r_idle_cnt;
`endif

    // r_rxd_d is the previous synchronized sample, so a start needs a real fall
    assign w_start_edge = r_rxd_d & ~r_rxd_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxd_s1     <= 1'b1;
            r_rxd_s2     <= 1'b1;
            r_rxd_d      <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_byte       <= '0;
            r_word       <= '0;
            r_data_64    <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte_cnt   <= '0;
`ifdef RX_TIMEOUT_EN
            r_idle_cnt   <= '0;
`endif
        end else begin
            r_rxd_s1     <= rx.uart_rxd;
            r_rxd_s2     <= r_rxd_s1;
            r_rxd_d      <= r_rxd_s2;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rxd_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_byte    <= {r_rxd_s2, r_byte[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_rxd_s2) begin
                            // earlier bytes shift up so the first lands in [63:56]
                            if (r_byte_cnt == 3'd7) begin
                                r_data_64    <= {r_word, r_byte};
                                r_data_valid <= 1'b1;
                                r_word       <= '0;
                            end else begin
                                r_word <= {r_word[47:0], r_byte};
                            end
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_word      <= '0;
                            r_byte_cnt  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

`ifdef RX_TIMEOUT_EN
            if (r_state == S_IDLE && r_byte_cnt != 3'd0 && r_rxd_s2) begin
                if (r_idle_cnt == c_TO_LAST) begin
                    r_idle_cnt <= '0;
                    r_byte_cnt <= '0;
                    r_word     <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
`endif
        end
    end

    assign rx.data_64    = r_data_64;
    assign rx.data_valid = r_data_valid;
    assign rx.frame_err  = r_frame_err;
    assign rx.byte_cnt   = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_64
//  Purpose  : Self-checking bench for uart_rx_64 (vector table plus corner cases).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_64;

    // Short bit period keeps the run brief; the glitch stays well under half a bit.
    localparam int c_BIT    = 64;
    localparam int c_GLITCH = 20;
    localparam int c_NVEC   = 27;
`ifdef RX_TIMEOUT_EN
    localparam logic [2:0] c_EXP_TO_CNT = 3'd0;
`else
    localparam logic [2:0] c_EXP_TO_CNT = 3'd3;
`endif

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          exp_valid;
        int          exp_ferr;
        logic [2:0]  exp_cnt;
        logic [63:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_64_if bus ();

    uart_rx_64 #(
        .CLK_F       (50_000_000),
        .UART_BPS    (115200),
        .CLK_GOAL    (c_BIT),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_both   = 0;

    always @(negedge clk) begin
        if (bus.data_valid) n_valid++;
        if (bus.frame_err) n_ferr++;
        if (bus.data_valid && bus.frame_err) n_both++;
    end

    vec_t        vecs[c_NVEC];
    logic [63:0] w1;
    logic [63:0] w2;
    int          v0;
    int          f0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        bus.uart_rxd = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int b = 0; b < 8; b++) bit_time(d[b]);
        bit_time(stop);
        bit_time(1'b1);
    endtask

    task automatic set_vec(input int idx, input logic [7:0] d, input logic stop,
                           input int ev, input int ef, input logic [2:0] cnt,
                           input logic [63:0] ed);
        vecs[idx].data      = d;
        vecs[idx].stop      = stop;
        vecs[idx].exp_valid = ev;
        vecs[idx].exp_ferr  = ef;
        vecs[idx].exp_cnt   = cnt;
        vecs[idx].exp_data  = ed;
    endtask

    task automatic check_outputs(input string tag, input logic [63:0] ed, input logic [2:0] ec);
        check64({tag, " data_64"}, bus.data_64, ed);
        check_int({tag, " byte_cnt"}, int'(bus.byte_cnt), int'(ec));
    endtask

    initial begin
        w1 = 64'h2CFF0AEF8AE16865;
        w2 = 64'hE429F657A7C2DB78;

        // word 1, word 2 back-to-back, two good bytes then a bad stop, then word 1 again
        for (int i = 0; i < 8; i++) begin
            set_vec(i, w1[63-8*i -: 8], 1'b1, (i == 7) ? 1 : 0, 0, 3'((i + 1) % 8),
                    (i == 7) ? w1 : 64'h0);
            set_vec(8 + i, w2[63-8*i -: 8], 1'b1, (i == 7) ? 1 : 0, 0, 3'((i + 1) % 8),
                    (i == 7) ? w2 : w1);
            set_vec(19 + i, w1[63-8*i -: 8], 1'b1, (i == 7) ? 1 : 0, 0, 3'((i + 1) % 8),
                    (i == 7) ? w1 : w2);
        end
        set_vec(16, 8'h2C, 1'b1, 0, 0, 3'd1, w2);
        set_vec(17, 8'hFF, 1'b1, 0, 0, 3'd2, w2);
        set_vec(18, 8'h0A, 1'b0, 0, 1, 3'd0, w2);

        rst_n        = 1'b0;
        bus.uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs("reset", 64'h0, 3'd0);
        check_int("reset data_valid", int'(bus.data_valid), 0);
        check_int("reset frame_err", int'(bus.frame_err), 0);
        rst_n = 1'b1;
        repeat (c_BIT) @(negedge clk);

        for (int i = 0; i < c_NVEC; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop);
            check_int($sformatf("vec%0d valid", i), n_valid - v0, vecs[i].exp_valid);
            check_int($sformatf("vec%0d ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_cnt);
        end

        // short low glitch on an idle line must be rejected
        v0 = n_valid;
        f0 = n_ferr;
        bus.uart_rxd = 1'b0;
        repeat (c_GLITCH) @(negedge clk);
        bus.uart_rxd = 1'b1;
        repeat (3 * c_BIT) @(negedge clk);
        check_int("glitch pulses", (n_valid - v0) + (n_ferr - f0), 0);
        check_outputs("glitch", w1, 3'd0);
        send_frame(8'hA5, 1'b1);
        check_outputs("after glitch", w1, 3'd1);

        // three bytes then a long idle
        send_frame(8'h3C, 1'b1);
        send_frame(8'h5A, 1'b1);
        check_int("three bytes cnt", int'(bus.byte_cnt), 3);
        v0 = n_valid;
        f0 = n_ferr;
        repeat (25 * c_BIT) @(negedge clk);
        check_outputs("idle timeout", w1, c_EXP_TO_CNT);
        check_int("idle pulses", (n_valid - v0) + (n_ferr - f0), 0);

        // bad stop clears any partial word; line held low afterwards starts nothing
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h81, 1'b0);
        check_int("bad stop ferr", n_ferr - f0, 1);
        check_int("bad stop valid", n_valid - v0, 0);
        check_outputs("bad stop", w1, 3'd0);

        // reset during bit 4 of byte 5
        for (int i = 0; i < 4; i++) send_frame(w2[63-8*i -: 8], 1'b1);
        check_int("pre-reset cnt", int'(bus.byte_cnt), 4);
        v0 = n_valid;
        f0 = n_ferr;
        bit_time(1'b0);
        for (int b = 0; b < 4; b++) bit_time(w2[24 + b]);
        bus.uart_rxd = w2[28];
        repeat (c_BIT / 2) @(negedge clk);
        rst_n        = 1'b0;
        bus.uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("mid reset", 64'h0, 3'd0);
        check_int("mid reset valid", int'(bus.data_valid), 0);
        check_int("mid reset ferr", int'(bus.frame_err), 0);
        rst_n = 1'b1;
        repeat (12 * c_BIT) @(negedge clk);
        check_int("post reset pulses", (n_valid - v0) + (n_ferr - f0), 0);
        check_outputs("post reset", 64'h0, 3'd0);

        v0 = n_valid;
        for (int i = 0; i < 8; i++) send_frame(w1[63-8*i -: 8], 1'b1);
        check_int("final word valid", n_valid - v0, 1);
        check_outputs("final word", w1, 3'd0);

        check_int("valid and ferr together", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
